// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the filter datapath stages:
// rounding modes, signed clipping helper and statistics counter width.
package fxp_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC,
        RND_HALF_UP,
        RND_CONVERGENT
    } rnd_mode_e;

    localparam int FXP_SAT_CNT_W = 16;

    // Clip a signed value to the range of a signed 'width'-bit number.
    function automatic logic signed [31:0] sat_clip(input logic signed [31:0] value,
                                                     input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/fxp_skid_buffer.sv
// Two-entry valid/ready skid buffer with a registered upstream ready.
// Entry 'head' drives the output directly, so m-side outputs are registered.
module fxp_skid_buffer #(
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    input  logic [W-1:0] i_s_data,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic [W-1:0] o_m_data
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         s_ready_q;
    logic         push;
    logic         pop;

    assign push = i_s_valid & s_ready_q;
    assign pop  = (count_q != 2'd0) & i_m_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_d = i_s_data;
                end else begin
                    tail_d = i_s_data;
                end
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                head_d  = tail_q;
            end
            2'b11: begin
                // Count unchanged: with one entry the new sample flows straight into head.
                if (count_q == 2'd1) begin
                    head_d = i_s_data;
                end else begin
                    head_d = tail_q;
                    tail_d = i_s_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q   <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
            s_ready_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            s_ready_q <= (count_d != 2'd2);
        end
    end

    assign o_s_ready = s_ready_q;
    assign o_m_valid = (count_q != 2'd0);
    assign o_m_data  = head_q;

endmodule

// File: rtl/fixed_point_requantizer.sv
// Re-quantizes the adder's widened sum: round offset, arithmetic shift, saturate.
// Optional saturation statistics are enabled by FXP_REQUANT_SAT_STATS_EN.
module fixed_point_requantizer
    import fxp_pkg::*;
#(
    parameter int        IN_W       = 9,
    parameter int        IN_FRAC    = 4,
    parameter int        OUT_W      = 8,
    parameter int        OUT_FRAC   = 3,
    parameter rnd_mode_e ROUND_MODE = RND_HALF_UP
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [IN_W-1:0]   i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [OUT_W-1:0]  o_data,
    output logic                     o_sat
`ifdef FXP_REQUANT_SAT_STATS_EN
    ,
    output logic [FXP_SAT_CNT_W-1:0] o_sat_count,
    output logic                     o_sat_sticky
`endif
);

    localparam int SH = IN_FRAC - OUT_FRAC;
    localparam int SW = IN_W + 1;

    if (IN_FRAC < OUT_FRAC) begin : g_bad_frac
        $error("fixed_point_requantizer: IN_FRAC must be >= OUT_FRAC");
    end

    logic                   adv;
    logic signed [SW-1:0]   in_ext;
    logic signed [SW-1:0]   offset;
    logic signed [SW-1:0]   sum;
    logic                   s1_valid_q;
    logic signed [SW-1:0]   s1_sum_q;
    logic signed [31:0]     shifted32;
    logic signed [31:0]     clipped32;
    logic                   s2_valid_q;
    logic [OUT_W-1:0]       s2_data_q;
    logic                   s2_sat_q;
    logic                   skid_ready;
    logic [OUT_W:0]         m_data;

    assign in_ext = {i_data[IN_W-1], i_data};

    if (SH == 0) begin : g_no_round
        assign offset = '0;
    end else begin : g_round
        localparam logic [SW-1:0] ONE     = {{(SW-1){1'b0}}, 1'b1};
        localparam logic [SW-1:0] HALF    = ONE << (SH - 1);
        localparam logic [SW-1:0] HALF_M1 = HALF - ONE;
        logic tie_even;

        // Exact half with an even kept LSB: round down so ties land on even.
        assign tie_even = (i_data[SH-1:0] == HALF[SH-1:0]) && !i_data[SH];

        always_comb begin
            offset = '0;
            case (ROUND_MODE)
                RND_TRUNC:      offset = '0;
                RND_HALF_UP:    offset = HALF;
                RND_CONVERGENT: offset = tie_even ? HALF_M1 : HALF;
                default:        offset = '0;
            endcase
        end
    end

    assign sum = in_ext + offset;
    assign adv = skid_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
        end else if (adv) begin
            s1_valid_q <= i_valid;
            s1_sum_q   <= sum;
        end
    end

    assign shifted32 = 32'(s1_sum_q) >>> SH;
    assign clipped32 = sat_clip(shifted32, OUT_W);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= clipped32[OUT_W-1:0];
            s2_sat_q   <= (clipped32 != shifted32);
        end
    end

    fxp_skid_buffer #(
        .W (OUT_W + 1)
    ) u_skid (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_s_valid (s2_valid_q),
        .o_s_ready (skid_ready),
        .i_s_data  ({s2_sat_q, s2_data_q}),
        .o_m_valid (o_valid),
        .i_m_ready (i_ready),
        .o_m_data  (m_data)
    );

    assign o_ready = skid_ready;
    assign o_sat   = m_data[OUT_W];
    assign o_data  = m_data[OUT_W-1:0];

`ifdef FXP_REQUANT_SAT_STATS_EN
    logic [FXP_SAT_CNT_W-1:0] sat_count_q;
    logic                     sat_sticky_q;
    logic                     sat_xfer;

    assign sat_xfer = o_valid & i_ready & o_sat;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sat_count_q  <= '0;
            sat_sticky_q <= 1'b0;
        end else if (sat_xfer) begin
            if (sat_count_q != {FXP_SAT_CNT_W{1'b1}}) begin
                sat_count_q <= sat_count_q + 1'b1;
            end
            sat_sticky_q <= 1'b1;
        end
    end

    assign o_sat_count  = sat_count_q;
    assign o_sat_sticky = sat_sticky_q;
`else
    // Statistics disabled: no counter or sticky flag in this build.
`endif

endmodule

// File: tb/tb_fixed_point_requantizer.sv
// Self-checking bench: three DUTs (TRUNC, HALF_UP, CONVERGENT) share one stimulus
// stream and are scored against an arithmetic rounding/saturation model.
`timescale 1ns/1ps
module tb_fixed_point_requantizer;
    import fxp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic signed [8:0] in_data;

    logic              rdy_t, rdy_h, rdy_c;
    logic              vld_t, vld_h, vld_c;
    logic signed [7:0] dat_t, dat_h, dat_c;
    logic              sat_t, sat_h, sat_c;
`ifdef FXP_REQUANT_SAT_STATS_EN
    logic [15:0]       cnt_t, cnt_h, cnt_c;
    logic              stk_t, stk_h, stk_c;
`endif

    fixed_point_requantizer #(.IN_W(9), .IN_FRAC(4), .OUT_W(8), .OUT_FRAC(3),
                              .ROUND_MODE(RND_TRUNC)) u_trunc (
        .i_clk(clk), .i_reset(rst), .i_valid(in_valid), .o_ready(rdy_t),
        .i_data(in_data), .o_valid(vld_t), .i_ready(out_ready),
        .o_data(dat_t), .o_sat(sat_t)
`ifdef FXP_REQUANT_SAT_STATS_EN
        , .o_sat_count(cnt_t), .o_sat_sticky(stk_t)
`endif
    );

    fixed_point_requantizer #(.IN_W(9), .IN_FRAC(4), .OUT_W(8), .OUT_FRAC(3),
                              .ROUND_MODE(RND_HALF_UP)) u_half (
        .i_clk(clk), .i_reset(rst), .i_valid(in_valid), .o_ready(rdy_h),
        .i_data(in_data), .o_valid(vld_h), .i_ready(out_ready),
        .o_data(dat_h), .o_sat(sat_h)
`ifdef FXP_REQUANT_SAT_STATS_EN
        , .o_sat_count(cnt_h), .o_sat_sticky(stk_h)
`endif
    );

    fixed_point_requantizer #(.IN_W(9), .IN_FRAC(4), .OUT_W(8), .OUT_FRAC(3),
                              .ROUND_MODE(RND_CONVERGENT)) u_conv (
        .i_clk(clk), .i_reset(rst), .i_valid(in_valid), .o_ready(rdy_c),
        .i_data(in_data), .o_valid(vld_c), .i_ready(out_ready),
        .o_data(dat_c), .o_sat(sat_c)
`ifdef FXP_REQUANT_SAT_STATS_EN
        , .o_sat_count(cnt_c), .o_sat_sticky(stk_c)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int exp_q[$];
    int acc_log[$];
    int out_log[$];
    bit stall_pend = 0;
    int stall_data, stall_sat;
    int last_dt, last_dh, last_dc, last_st, last_sh, last_sc;

    typedef struct {
        int din;
        int et, eh, ec;
        int st, sh, sc;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int floor_half(input int x);
        int r;
        r = ((x % 2) + 2) % 2;
        return (x - r) / 2;
    endfunction

    // Value / 2^SH (SH=1) rounded per mode, then clipped to signed 8 bits.
    task automatic ref_val(input int x, input rnd_mode_e mode, output int v, output int s);
        int q;
        case (mode)
            RND_TRUNC:   q = floor_half(x);
            RND_HALF_UP: q = floor_half(x + 1);
            default: begin
                q = floor_half(x);
                if ((x - 2 * q) == 1 && (q % 2) != 0) q = q + 1;
            end
        endcase
        v = q;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        s = (v != q) ? 1 : 0;
    endtask

    task automatic cycle(output bit acc, output bit xfer);
        int x, e, s;
        acc  = !rst && in_valid && rdy_h;
        xfer = !rst && vld_h && out_ready;
        if (stall_pend) begin
            check("stall_valid", int'(vld_h), 1);
            check("stall_data", int'(dat_h), stall_data);
            check("stall_sat", int'(sat_h), stall_sat);
        end
        stall_pend = !rst && vld_h && !out_ready;
        stall_data = int'(dat_h);
        stall_sat  = int'(sat_h);
        if (xfer) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", int'(vld_h), 0);
            end else begin
                x = exp_q.pop_front();
                ref_val(x, RND_HALF_UP, e, s);
                check("data_half", int'(dat_h), e);
                check("sat_half", int'(sat_h), s);
                ref_val(x, RND_TRUNC, e, s);
                check("valid_trunc", int'(vld_t), 1);
                check("data_trunc", int'(dat_t), e);
                check("sat_trunc", int'(sat_t), s);
                ref_val(x, RND_CONVERGENT, e, s);
                check("valid_conv", int'(vld_c), 1);
                check("data_conv", int'(dat_c), e);
                check("sat_conv", int'(sat_c), s);
            end
            last_dt = int'(dat_t); last_dh = int'(dat_h); last_dc = int'(dat_c);
            last_st = int'(sat_t); last_sh = int'(sat_h); last_sc = int'(sat_c);
            out_log.push_back(cyc);
        end
        if (acc) begin
            exp_q.push_back(int'(in_data));
            acc_log.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            stall_pend = 0;
        end
    endtask

    task automatic send_one(input int v);
        bit a, x, got;
        in_valid = 1'b1;
        in_data  = 9'(v);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle(a, x);
            if (a) got = 1;
        end
        in_valid = 1'b0;
        check("accept_timeout", int'(got), 1);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle(a, x);
            if (x) got = 1;
        end
        check("output_timeout", int'(got), 1);
    endtask

    task automatic drain();
        bit a, x;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) cycle(a, x);
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit a, x, saw_low;
        int n, xfers;

        vecs[0] = '{5,    2,    3,    2,    0, 0, 0};
        vecs[1] = '{7,    3,    4,    4,    0, 0, 0};
        vecs[2] = '{255,  127,  127,  127,  0, 1, 1};
        vecs[3] = '{-256, -128, -128, -128, 0, 0, 0};
        vecs[4] = '{-1,   -1,   0,    0,    0, 0, 0};
        vecs[5] = '{3,    1,    2,    2,    0, 0, 0};
        vecs[6] = '{-255, -128, -127, -128, 0, 0, 0};
        vecs[7] = '{254,  127,  127,  127,  0, 0, 0};
        vecs[8] = '{0,    0,    0,    0,    0, 0, 0};
        vecs[9] = '{-3,   -2,   -1,   -2,   0, 0, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        repeat (3) cycle(a, x);
        check("reset_valid", int'(vld_h), 0);
        check("reset_ready", int'(rdy_h), 0);
        check("reset_data", int'(dat_h), 0);
        check("reset_sat", int'(sat_h), 0);
        rst = 1'b0;
        cycle(a, x);
        check("ready_after_reset_h", int'(rdy_h), 1);
        check("ready_after_reset_t", int'(rdy_t), 1);
        check("ready_after_reset_c", int'(rdy_c), 1);

        // Directed rounding / saturation table
        foreach (vecs[i]) begin
            send_one(vecs[i].din);
            check($sformatf("tbl%0d_trunc", i), last_dt, vecs[i].et);
            check($sformatf("tbl%0d_half", i), last_dh, vecs[i].eh);
            check($sformatf("tbl%0d_conv", i), last_dc, vecs[i].ec);
            check($sformatf("tbl%0d_sat_trunc", i), last_st, vecs[i].st);
            check($sformatf("tbl%0d_sat_half", i), last_sh, vecs[i].sh);
            check($sformatf("tbl%0d_sat_conv", i), last_sc, vecs[i].sc);
        end

        // Back-to-back random streaming
        acc_log.delete(); out_log.delete();
        n = 0;
        in_valid = 1'b1;
        in_data = 9'($urandom_range(0, 511));
        for (int k = 0; k < 100 && n < 20; k++) begin
            cycle(a, x);
            if (a) begin
                n++;
                in_data = 9'($urandom_range(0, 511));
            end
        end
        in_valid = 1'b0;
        drain();
        check("stream_accepts", acc_log.size(), 20);
        check("stream_outputs", out_log.size(), 20);
        if (acc_log.size() == 20 && out_log.size() == 20) begin
            check("stream_latency", out_log[0] - acc_log[0], 2);
            check("stream_in_rate", acc_log[19] - acc_log[0], 19);
            check("stream_out_rate", out_log[19] - out_log[0], 19);
        end

        // Back-pressure: i_ready low for 5 cycles during continuous input
        acc_log.delete(); out_log.delete();
        n = 0; saw_low = 0;
        for (int k = 0; k < 60; k++) begin
            out_ready = !(k >= 5 && k < 10);
            in_valid  = (n < 30);
            if (in_valid) in_data = 9'($urandom_range(0, 511));
            cycle(a, x);
            if (a) n++;
            if (!rdy_h) saw_low = 1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
        check("bp_ready_fell", int'(saw_low), 1);
        check("bp_accepts", acc_log.size(), 30);
        check("bp_outputs", out_log.size(), 30);
        check("bp_ready_recovered", int'(rdy_h), 1);

        // Reset with 3 samples in flight
        n = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && n < 3; k++) begin
            in_data = 9'($urandom_range(0, 511));
            cycle(a, x);
            if (a) n++;
        end
        in_valid = 1'b0;
        in_data  = 9'(255);
        rst = 1'b1;
        cycle(a, x);
        check("midrst_valid", int'(vld_h), 0);
        check("midrst_ready", int'(rdy_h), 0);
        rst = 1'b0;
        xfers = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(a, x);
            if (vld_h) xfers++;
        end
        check("midrst_stale", xfers, 0);
        check("midrst_ready_back", int'(rdy_h), 1);
`ifdef FXP_REQUANT_SAT_STATS_EN
        check("midrst_count", int'(cnt_h), 0);
        check("midrst_sticky", int'(stk_h), 0);

        // Statistics: 3 clipped (one held under stall) and 2 clean samples
        send_one(255);
        check("stats_sticky_first", int'(stk_h), 1);
        send_one(5);
        send_one(255);
        send_one(-100);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 9'(255);
        n = 0;
        for (int k = 0; k < 20 && n < 1; k++) begin
            cycle(a, x);
            if (a) n++;
        end
        in_valid = 1'b0;
        repeat (6) cycle(a, x);
        check("stats_held_count", int'(cnt_h), 2);
        out_ready = 1'b1;
        drain();
        repeat (2) cycle(a, x);
        check("stats_count_half", int'(cnt_h), 3);
        check("stats_sticky_half", int'(stk_h), 1);
        check("stats_count_trunc", int'(cnt_t), 0);
        check("stats_sticky_trunc", int'(stk_t), 0);
        check("stats_count_conv", int'(cnt_c), 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
